// File: rtl/nd_nto1_rr.sv
// nd_nto1_rr: NCH-input round-robin merger of 4-phase req/ack message channels into one 4-phase output, via an FSZ-deep FIFO.
// Optional NS_NTO1_SRC_TAG_EN adds snd0_src, the granted channel index carried alongside each message.
`ifndef NS_2to1_FSZ
`define NS_2to1_FSZ 4
`endif
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module nd_nto1_rr #(
  parameter int NCH = 4,
  parameter int FSZ = `NS_2to1_FSZ,
  parameter int ASZ = `NS_ADDRESS_SIZE,
  parameter int DSZ = `NS_DATA_SIZE,
  parameter int RSZ = `NS_REDUN_SIZE
) (
  input  logic                   i_clk,
  input  logic                   reset,
  output logic                   ready,
  output logic [ASZ-1:0]         snd0_addr,
  output logic [DSZ-1:0]         snd0_dat,
  output logic [RSZ-1:0]         snd0_red,
`ifdef NS_NTO1_SRC_TAG_EN
  output logic [$clog2(NCH)-1:0] snd0_src,
`endif
  output logic                   snd0_req,
  input  logic                   snd0_ack,
  input  logic [NCH*ASZ-1:0]     rcv_addr,
  input  logic [NCH*DSZ-1:0]     rcv_dat,
  input  logic [NCH*RSZ-1:0]     rcv_red,
  input  logic [NCH-1:0]         rcv_req,
  output logic [NCH-1:0]         rcv_ack
);
  localparam int PW = $clog2(NCH);
  localparam int IW = $clog2(FSZ);
  localparam int CW = IW + 1;
  localparam int BW = ASZ + DSZ + RSZ;
`ifdef NS_NTO1_SRC_TAG_EN
  localparam int MW = PW + BW;
`else
  localparam int MW = BW;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_RELEASE} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_start;
  logic [PW-1:0]    r_ptr;
  logic [IW-1:0]    r_head, r_tail;
  logic [CW-1:0]    r_cnt;
  logic [MW-1:0]    r_mem [FSZ];

  logic [NCH-1:0]   w_pend;
  logic [PW:0]      w_cand;
  logic             w_gnt_vld;
  logic [PW-1:0]    w_gnt_idx;
  logic [PW-1:0]    w_ptr_nxt;
  logic             w_full, w_empty, w_push, w_pop, w_req_clr;
  logic [MW-1:0]    w_wr_msg, w_rd_msg;

  assign w_pend  = rcv_req & ~rcv_ack;
  assign w_full  = (r_cnt == CW'(FSZ));
  assign w_empty = (r_cnt == '0);

  // Rotating scan from r_ptr; the first pending channel in that order wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int i = 0; i < NCH; i++) begin
      w_cand = {1'b0, r_ptr} + (PW+1)'(i);
      if (w_cand >= (PW+1)'(NCH)) w_cand = w_cand - (PW+1)'(NCH);
      if (!w_gnt_vld && w_pend[w_cand[PW-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand[PW-1:0];
      end
    end
  end

  assign w_push    = ready && w_gnt_vld && !w_full;
  assign w_ptr_nxt = (w_gnt_idx == PW'(NCH-1)) ? '0 : w_gnt_idx + 1'b1;

`ifdef NS_NTO1_SRC_TAG_EN
  assign w_wr_msg = {w_gnt_idx, rcv_addr[w_gnt_idx*ASZ +: ASZ],
                     rcv_dat[w_gnt_idx*DSZ +: DSZ], rcv_red[w_gnt_idx*RSZ +: RSZ]};
`else
  assign w_wr_msg = {rcv_addr[w_gnt_idx*ASZ +: ASZ],
                     rcv_dat[w_gnt_idx*DSZ +: DSZ], rcv_red[w_gnt_idx*RSZ +: RSZ]};
`endif
  assign w_rd_msg = r_mem[r_head];

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_req_clr   = 1'b0;
    case (r_state)
      ST_IDLE:    if (ready && !w_empty) begin w_pop = 1'b1; w_state_nxt = ST_SEND; end
      ST_SEND:    if (snd0_ack) begin w_req_clr = 1'b1; w_state_nxt = ST_RELEASE; end
      ST_RELEASE: if (!snd0_ack) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // ready lags the release by two edges: r_start marks the init cycle.
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      r_start <= 1'b0;
      ready   <= 1'b0;
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_cnt   <= '0;
      rcv_ack <= '0;
    end else begin
      r_start <= 1'b1;
      ready   <= r_start;
      r_state <= w_state_nxt;
      if (w_push) begin
        r_ptr  <= w_ptr_nxt;
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      for (int k = 0; k < NCH; k++) begin
        if (w_push && w_gnt_idx == PW'(k)) rcv_ack[k] <= 1'b1;
        else if (!rcv_req[k])              rcv_ack[k] <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_tail] <= w_wr_msg;
  end

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      snd0_req  <= 1'b0;
      snd0_addr <= '0;
      snd0_dat  <= '0;
      snd0_red  <= '0;
`ifdef NS_NTO1_SRC_TAG_EN
      snd0_src  <= '0;
`endif
    end else if (w_pop) begin
      snd0_req  <= 1'b1;
      snd0_addr <= w_rd_msg[BW-1 -: ASZ];
      snd0_dat  <= w_rd_msg[DSZ+RSZ-1 -: DSZ];
      snd0_red  <= w_rd_msg[RSZ-1:0];
`ifdef NS_NTO1_SRC_TAG_EN
      snd0_src  <= w_rd_msg[MW-1 -: PW];
`endif
    end else if (w_req_clr) begin
      snd0_req  <= 1'b0;
    end
  end

endmodule
